mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Multi-cycle RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the MDU operation and operands latched by ID/EX. Asserts a stall back to ID/EX and the fetch/decode stages while it computes.
- Returns a single-cycle result to the EX result mux.
- Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and >= 8.

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_flush  in  1  abort any operation in progress; discard its result.
- i_start  in  1  request an operation. Driven high while ID/EX holds a valid MDU instruction.
- i_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_dataA  in  DATA_WIDTH  rs1 operand.
- i_dataB  in  DATA_WIDTH  rs2 operand.
- o_stall  out  1  hold upstream pipeline registers.
- o_valid  out  1  o_result valid this cycle.
- o_result  out  DATA_WIDTH  operation result.

Behaviour:
- Reset (i_reset=0, async):
  - state=IDLE; all internal registers 0.
  - o_valid=0, o_result=0.
  - o_stall=0 regardless of i_start.
  - Operation in progress is lost; no o_valid is issued for it.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If i_start=1, i_flush=0 and the operands are not a fast case: latch op and operands, and the absolute values for signed operands (MULH: both signed; MULHSU: A signed, B unsigned; DIV/REM: both signed).
  - Clear the counter and go to CALC.
  - o_stall=1 combinationally in this cycle.
- Fast cases (DIV/DIVU/REM/REMU only), entered from IDLE when i_start=1 and i_flush=0:
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed overflow (A=MIN, B=-1): quotient = MIN, remainder = 0.
  - Go directly to DONE. o_stall=1 in the start cycle.
- CALC:
  - Exactly DATA_WIDTH cycles, one iteration per cycle, counter 0..DATA_WIDTH-1.
  - Multiply: 2*DATA_WIDTH-bit product accumulator.
  - Divide: restoring, DATA_WIDTH-bit remainder register plus 1 guard bit.
  - o_stall=1.
- FIX:
  - One cycle.
  - Multiply: negate the product if the operand signs differ.
  - DIV: negate the quotient if the signs differ.
  - REM: remainder takes the dividend's sign.
  - Select the result: low half for MUL; high half for MULH/MULHSU/MULHU.
  - Register o_result. o_stall=1.
- DONE:
  - One cycle, o_valid=1, o_stall=0. Upstream advances on this edge.
  - Next state is IDLE.
  - i_start in DONE is ignored: the same instruction is still in EX this cycle.
- Latency (normal ops):
  - i_start sampled at edge k.
  - CALC during cycles k+1..k+DATA_WIDTH, FIX at k+DATA_WIDTH+1, o_valid at cycle k+DATA_WIDTH+2.
  - Total 35 cycles for width 32.
- Latency (fast ops): o_valid in cycle k+1.
- o_result holds its last value when o_valid=0.
- i_start while in CALC/FIX/DONE is ignored; operands are not re-sampled.
- i_flush:
  - In CALC/FIX/DONE: next state IDLE, no o_valid, o_stall=0 in the flush cycle.
  - In IDLE: suppresses start.
  - i_flush together with i_start in IDLE: no start.
- Output reset values: o_stall=0, o_valid=0, o_result=0.

Test Plan:
- Reset, then MUL with A=7, B=0xFFFFFFFD -> o_stall high 34 cycles; o_valid exactly one cycle at start+34; o_result=0xFFFFFFEB.
- MULHU A=B=0xFFFFFFFF -> o_result=0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF and REM 0x1234/0 -> 0x1234, with o_valid at start+1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0.
- Flush at start+10 -> o_stall low that cycle, no o_valid. Next start MUL 3*5 -> 15 with full latency.
- Assert i_reset low asynchronously (mid-cycle) at start+20 -> o_stall and o_valid drop immediately. Release and restart DIVU 9/3 -> 3; no stale o_valid.

Source files
------------

// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the ID/EX stage and the iterative multiply/divide unit.
interface mdu_iterative_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_flush;
  logic                  i_start;
  logic [2:0]            i_op;
  logic [DATA_WIDTH-1:0] i_dataA;
  logic [DATA_WIDTH-1:0] i_dataB;
  logic                  o_stall;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_result;

  // Pipeline side: issues operations, consumes stall/result.
  modport master (
    output i_flush, i_start, i_op, i_dataA, i_dataB,
    input  o_stall, o_valid, o_result
  );

  // MDU side.
  modport slave (
    input  i_flush, i_start, i_op, i_dataA, i_dataB,
    output o_stall, o_valid, o_result
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per
// cycle, with a sign-fixup cycle and a one-cycle result strobe. Division by zero and signed
// overflow bypass the iteration and answer on the following cycle.
module mdu_iterative #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic            i_clock,
  input logic            i_reset,
  mdu_iterative_if.slave bus
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W);

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpRem    = 3'd6;

  localparam logic [W-1:0] MinVal  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] AllOnes = {W{1'b1}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [W-1:0]    mag_q, mag_d;    // |A| for multiply, |B| (divisor) for divide
  logic [2*W-1:0]  acc_q, acc_d;    // product; low half doubles as dividend/quotient shifter
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    result_q, result_d;
  logic            stall, valid;

  logic [2:0]      op;
  logic [W-1:0]    a, b;
  logic            a_signed, b_signed, sign_a, sign_b;
  logic [W-1:0]    abs_a, abs_b;
  logic            neg_start, div_zero, div_ovf, fast;
  logic [W-1:0]    fast_result;

  logic [W:0]      mul_sum;
  logic [W:0]      div_part;         // shifted partial remainder including the guard bit
  logic            div_ge;
  logic [2*W-1:0]  prod_fixed;
  logic [W-1:0]    quot_fixed, rem_fixed, fix_result;

  assign op = bus.i_op;
  assign a  = bus.i_dataA;
  assign b  = bus.i_dataB;

  // Operand decode at issue: signedness, magnitudes, result sign and the bypass cases.
  always_comb begin
    a_signed  = (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
    b_signed  = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    sign_a    = a_signed & a[W-1];
    sign_b    = b_signed & b[W-1];
    abs_a     = sign_a ? -a : a;
    abs_b     = sign_b ? -b : b;
    // Remainder follows the dividend; everything else follows the XOR of the signs.
    neg_start = (op[2] & op[1]) ? sign_a : (sign_a ^ sign_b);
    div_zero  = (b == '0);
    div_ovf   = ((op == OpDiv) || (op == OpRem)) && (a == MinVal) && (b == AllOnes);
    fast      = op[2] & (div_zero | div_ovf);
    if (op[1]) begin
      fast_result = div_zero ? a : '0;
    end else begin
      fast_result = div_zero ? AllOnes : MinVal;
    end
  end

  // One multiply/divide iteration and the final sign fixup / half selection.
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, mag_q};
    div_part   = {rem_q, acc_q[W-1]};
    div_ge     = (div_part >= {1'b0, mag_q});
    prod_fixed = neg_q ? -acc_q : acc_q;
    quot_fixed = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fixed  = neg_q ? -rem_q : rem_q;
    if (op_q[2]) begin
      fix_result = op_q[1] ? rem_fixed : quot_fixed;
    end else begin
      fix_result = (op_q == OpMul) ? prod_fixed[W-1:0] : prod_fixed[2*W-1:W];
    end
  end

  // Control FSM and datapath next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    stall    = 1'b0;
    valid    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.i_start && !bus.i_flush) begin
          stall = 1'b1;
          op_d  = op;
          neg_d = neg_start;
          if (fast) begin
            result_d = fast_result;
            state_d  = StDone;
          end else begin
            cnt_d   = '0;
            rem_d   = '0;
            mag_d   = op[2] ? abs_b : abs_a;
            acc_d   = {{W{1'b0}}, (op[2] ? abs_a : abs_b)};
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (bus.i_flush) begin
          state_d = StIdle;
        end else begin
          stall = 1'b1;
          if (op_q[2]) begin
            rem_d = div_ge ? W'(div_part - {1'b0, mag_q}) : div_part[W-1:0];
            acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], div_ge};
          end else begin
            acc_d = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        if (bus.i_flush) begin
          state_d = StIdle;
        end else begin
          stall    = 1'b1;
          result_d = fix_result;
          state_d  = StDone;
        end
      end
      StDone: begin
        valid   = !bus.i_flush;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mag_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  // Reset forces stall/valid low immediately, even with a start request pending.
  assign bus.o_stall  = i_reset & stall;
  assign bus.o_valid  = i_reset & valid;
  assign bus.o_result = result_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed cases with literal expectations plus random traffic,
// all outputs checked every cycle against a latency/arithmetic reference model.
module tb_mdu_iterative;
  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mdu_iterative_if #(.DATA_WIDTH(W)) bus ();

  mdu_iterative #(.DATA_WIDTH(W)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Architectural RV32M result computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0]        ea, eb, p;
    logic signed [63:0] sa, sb, r;
    ea = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    r  = '0;
    case (op)
      3'd0:              return p[31:0];
      3'd1, 3'd2, 3'd3:  return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hffff_ffff;
        r = sa / sb;
        return r[31:0];
      end
      3'd5:    return (b == 0) ? 32'hffff_ffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        r = sa % sb;
        return r[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hffff_ffff));
  endfunction

  // Reference model: 'left' = cycles remaining until the result strobe (0 = idle).
  int          left    = 0;
  logic [31:0] pending = '0;
  logic [31:0] hold    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left = 0;
      hold = '0;
    end else if (left == 0) begin
      if (bus.i_start && !bus.i_flush) begin
        pending = ref_op(bus.i_op, bus.i_dataA, bus.i_dataB);
        left    = is_fast(bus.i_op, bus.i_dataA, bus.i_dataB) ? 1 : W + 2;
      end
    end else if (bus.i_flush) begin
      left = 0;
    end else begin
      if (left == 1) hold = pending;
      left = left - 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : compare
    logic es, ev;
    es = rst_n && !bus.i_flush && ((left == 0 && bus.i_start) || left >= 2);
    ev = rst_n && !bus.i_flush && left == 1;
    chk("stall", bus.o_stall, es);
    chk("valid", bus.o_valid, ev);
    if (rst_n && left == 1) chk("result", bus.o_result, pending);
    else                    chk("hold", bus.o_result, hold);
  end

  task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int          stalls, vat, extra;
    logic [31:0] res;
    stalls = 0;
    vat    = -1;
    extra  = 0;
    res    = '0;
    @(posedge clk);
    #1;
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_dataA = a;
    bus.i_dataB = b;
    for (int i = 0; i < 60 && vat < 0; i++) begin
      @(negedge clk);
      if (bus.o_stall) stalls++;
      if (bus.o_valid) begin
        vat = i;
        res = bus.o_result;
      end
    end
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.o_valid) extra++;
    end
    chk({nm, "_lat"}, 64'(vat), 64'(lat));
    chk({nm, "_stalls"}, 64'(stalls), 64'(lat));
    chk({nm, "_res"}, res, exp);
    chk({nm, "_extra_valid"}, 64'(extra), 64'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hffff_ffff;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_op();
    int fl;
    bit done;
    fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : -1;
    done = 1'b0;
    repeat ($urandom_range(0, 3)) @(posedge clk);
    @(posedge clk);
    #1;
    bus.i_start = 1'b1;
    bus.i_op    = 3'($urandom_range(0, 7));
    bus.i_dataA = rnd_val();
    bus.i_dataB = rnd_val();
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk);
      if (bus.o_valid) done = 1'b1;
      @(posedge clk);
      #1;
      if (done) begin
        bus.i_start = 1'b0;
      end else if (i == fl) begin
        bus.i_flush = 1'b1;
        bus.i_start = 1'b0;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        done = 1'b1;
      end
    end
    chk("rand_timeout", 64'(done), 64'd1);
    bus.i_start = 1'b0;
  endtask

  initial begin
    int extra;
    bus.i_flush = 1'b0;
    bus.i_start = 1'b1;  // stall must stay low in reset even with a request pending
    bus.i_op    = 3'd0;
    bus.i_dataA = '0;
    bus.i_dataB = '0;

    // Pin the reference model to hand-computed values.
    chk("pin_mul", ref_op(3'd0, 32'd7, 32'hffff_fffd), 32'hffff_ffeb);
    chk("pin_mulhsu", ref_op(3'd2, 32'hffff_ffff, 32'd2), 32'hffff_ffff);
    chk("pin_div", ref_op(3'd4, 32'hffff_fff9, 32'd2), 32'hffff_fffd);
    chk("pin_rem", ref_op(3'd6, 32'hffff_fff9, 32'd2), 32'hffff_ffff);
    chk("pin_ovf", ref_op(3'd4, 32'h8000_0000, 32'hffff_ffff), 32'h8000_0000);

    @(negedge clk);
    chk("rst_stall", bus.o_stall, 1'b0);
    chk("rst_valid", bus.o_valid, 1'b0);
    chk("rst_result", bus.o_result, 32'h0);
    bus.i_start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_op("mul", 3'd0, 32'd7, 32'hffff_fffd, 32'hffff_ffeb, 34);
    do_op("mulhu", 3'd3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 34);
    do_op("mulh", 3'd1, 32'hffff_ffff, 32'hffff_ffff, 32'h0, 34);
    do_op("mulhsu", 3'd2, 32'hffff_ffff, 32'd2, 32'hffff_ffff, 34);
    do_op("div", 3'd4, 32'hffff_fff9, 32'd2, 32'hffff_fffd, 34);
    do_op("rem", 3'd6, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 34);
    do_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 34);
    do_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 34);
    do_op("divu_z", 3'd5, 32'h1234, 32'h0, 32'hffff_ffff, 1);
    do_op("rem_z", 3'd6, 32'h1234, 32'h0, 32'h1234, 1);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hffff_ffff, 32'h0, 1);

    // Flush mid-calculation.
    @(posedge clk);
    #1;
    bus.i_start = 1'b1;
    bus.i_op    = 3'd0;
    bus.i_dataA = 32'd11;
    bus.i_dataB = 32'd13;
    repeat (10) @(posedge clk);
    #1;
    bus.i_flush = 1'b1;
    bus.i_start = 1'b0;
    @(negedge clk);
    chk("flush_stall", bus.o_stall, 1'b0);
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_valid) extra++;
    end
    chk("flush_no_valid", 64'(extra), 64'd0);
    do_op("mul_after_flush", 3'd0, 32'd3, 32'd5, 32'd15, 34);

    // Flush together with start in idle: nothing starts.
    @(posedge clk);
    #1;
    bus.i_start = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_op    = 3'd5;
    bus.i_dataA = 32'd9;
    bus.i_dataB = 32'd0;
    @(negedge clk);
    chk("flush_start_stall", bus.o_stall, 1'b0);
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_valid) extra++;
    end
    chk("flush_start_no_valid", 64'(extra), 64'd0);

    // Asynchronous reset mid-operation.
    @(posedge clk);
    #1;
    bus.i_start = 1'b1;
    bus.i_op    = 3'd0;
    bus.i_dataA = 32'h1234;
    bus.i_dataB = 32'h5678;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", bus.o_stall, 1'b0);
    chk("async_rst_valid", bus.o_valid, 1'b0);
    chk("async_rst_result", bus.o_result, 32'h0);
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op("divu_after_rst", 3'd5, 32'd9, 32'd3, 32'd3, 34);

    for (int n = 0; n < 50; n++) rand_op();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
